// File: rtl/tag_table.sv
// Rename-tag occupancy tracker for the ALU reservation-station pool and the
// load/store buffer pool: lowest free root per pool, full flags, busy counts.
module tag_table #(
  parameter int ROOT_W = 3,
  parameter int CNT_W  = ROOT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              alu_alloc,
  input  logic              ls_alloc,
  input  logic              alu_rel_en,
  input  logic [ROOT_W-1:0] alu_rel_root,
  input  logic              ls_rel_en,
  input  logic [ROOT_W-1:0] ls_rel_root,
  output logic [ROOT_W-1:0] ALUfreeTag,
  output logic [ROOT_W-1:0] LSfreeTag,
  output logic              alu_full,
  output logic              ls_full,
  output logic [CNT_W-1:0]  alu_cnt,
  output logic [CNT_W-1:0]  ls_cnt,
  output logic              alloc_err
);

  localparam int DEPTH = 1 << ROOT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] alu_busy, ls_busy;
  logic [DEPTH-1:0] alu_busy_nx, ls_busy_nx;
  logic [CNT_W-1:0] alu_cnt_nx, ls_cnt_nx;
  logic             alu_alloc_ok, ls_alloc_ok;
  logic             alu_rel_ok, ls_rel_ok;
  logic             alloc_overflow;

  // Handshake: alloc is a one-cycle consume of the currently presented free
  // tag; it takes effect only when rdy=1, flush=0 and the pool is not full.
  assign alu_full = (alu_cnt == FULL_CNT);
  assign ls_full  = (ls_cnt == FULL_CNT);

  assign alu_alloc_ok = alu_alloc && !alu_full;
  assign ls_alloc_ok  = ls_alloc && !ls_full;
  assign alu_rel_ok   = alu_rel_en && alu_busy[alu_rel_root];
  assign ls_rel_ok    = ls_rel_en && ls_busy[ls_rel_root];

  assign alloc_overflow = (alu_alloc && alu_full) || (ls_alloc && ls_full);

  // Lowest-index free root; a full pool falls through to 0.
  always_comb begin
    ALUfreeTag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!alu_busy[i]) ALUfreeTag = ROOT_W'(i);
    end
  end

  always_comb begin
    LSfreeTag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ls_busy[i]) LSfreeTag = ROOT_W'(i);
    end
  end

  // Allocated root is free and released root is busy, so they never collide.
  always_comb begin
    alu_busy_nx = alu_busy;
    if (alu_alloc_ok) alu_busy_nx[ALUfreeTag] = 1'b1;
    if (alu_rel_ok)   alu_busy_nx[alu_rel_root] = 1'b0;
    alu_cnt_nx = alu_cnt + {{(CNT_W-1){1'b0}}, alu_alloc_ok}
                         - {{(CNT_W-1){1'b0}}, alu_rel_ok};
  end

  always_comb begin
    ls_busy_nx = ls_busy;
    if (ls_alloc_ok) ls_busy_nx[LSfreeTag] = 1'b1;
    if (ls_rel_ok)   ls_busy_nx[ls_rel_root] = 1'b0;
    ls_cnt_nx = ls_cnt + {{(CNT_W-1){1'b0}}, ls_alloc_ok}
                       - {{(CNT_W-1){1'b0}}, ls_rel_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_busy  <= '0;
      ls_busy   <= '0;
      alu_cnt   <= '0;
      ls_cnt    <= '0;
      alloc_err <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        alu_busy <= '0;
        ls_busy  <= '0;
        alu_cnt  <= '0;
        ls_cnt   <= '0;
      end else begin
        alu_busy <= alu_busy_nx;
        ls_busy  <= ls_busy_nx;
        alu_cnt  <= alu_cnt_nx;
        ls_cnt   <= ls_cnt_nx;
        if (alloc_overflow) alloc_err <= 1'b1;
      end
    end
  end

endmodule
